// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Owns the single register-file write port (we3/a3/wd3) and shares it among
// NREQ result producers using a valid/ready handshake with round-robin
// arbitration. The write port is driven from one registered output stage, so a
// handshake in cycle N appears on we3/a3/wd3 in cycle N+1.
//
// Optional feature (compile-time macro REGFILE_WB_INIT_EN):
//   defined     - after reset the block zero-fills registers 1..31, one per
//                 cycle, before any requester is granted. init_done rises on
//                 the edge that posts the write to register 31.
//   not defined - no fill sequence; requests are grantable immediately after
//                 reset and init_done resets to 1.
//
// Parameters:
//   NREQ  number of write requesters (2..8)
//   AW    register address width
//   DW    register data width
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NREQ]     requester i has a write pending
//   req_addr   in   [NREQ*AW]  destination of requester i at [i*AW +: AW]
//   req_data   in   [NREQ*DW]  write data of requester i at [i*DW +: DW]
//   req_ready  out  [NREQ]     one-hot-or-zero grant (combinational)
//   we3        out             register-file write enable (registered)
//   a3         out  [AW]       register-file write address (registered)
//   wd3        out  [DW]       register-file write data (registered)
//   init_done  out             write port available to requesters (registered)
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 we3,
    output logic [AW-1:0]        a3,
    output logic [DW-1:0]        wd3,
    output logic                 init_done
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // -------------------------------------------------------------------------
    // Unpack the flat requester buses into per-requester arrays
    // -------------------------------------------------------------------------
    logic [AW-1:0] addr_arr [NREQ];
    logic [DW-1:0] data_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*AW +: AW];
            assign data_arr[gi] = req_data[gi*DW +: DW];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Zero-fill sequencer (optional)
    // -------------------------------------------------------------------------
    logic          in_run;      // arbitration active this cycle
    logic          run_next;    // arbitration active next cycle
    logic [AW-1:0] init_addr;   // register being zero-filled this cycle
    logic          init_done_rst;

`ifdef REGFILE_WB_INIT_EN
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= 5'd1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_INIT) begin
            if (cnt_q == 5'd31) begin
                // The edge that posts register 31 also hands the port over.
                state_d = ST_RUN;
            end else begin
                cnt_d = cnt_q + 5'd1;
            end
        end
    end

    assign in_run        = (state_q == ST_RUN);
    assign run_next      = (state_d == ST_RUN);
    assign init_addr     = AW'(cnt_q);
    assign init_done_rst = 1'b0;
`else
    assign in_run        = 1'b1;
    assign run_next      = 1'b1;
    assign init_addr     = '0;
    assign init_done_rst = 1'b1;
`endif

    // -------------------------------------------------------------------------
    // Round-robin grant: first valid requester searching ptr, ptr+1, ...
    // -------------------------------------------------------------------------
    logic [PW-1:0] ptr_q, ptr_d;
    logic          gnt_found;
    logic [PW-1:0] gnt_idx;
    logic [PW:0]   cand;
    logic          hs;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            // ptr + k wrapped to 0..NREQ-1; one subtraction suffices since
            // both terms are below NREQ.
            cand = {1'b0, ptr_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            if (!gnt_found && req_valid[cand[PW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[PW-1:0];
            end
        end
    end

    assign hs = in_run & gnt_found;

    // Ready is forced low while reset is held, even in builds without the
    // fill sequence where the block is otherwise always arbitrating.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = rst_n & hs & (gnt_idx == PW'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Output register stage and pointer update
    // -------------------------------------------------------------------------
    logic          we3_q, we3_d;
    logic [AW-1:0] a3_q, a3_d;
    logic [DW-1:0] wd3_q, wd3_d;
    logic          init_done_q, init_done_d;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    assign sel_addr = addr_arr[gnt_idx];
    assign sel_data = data_arr[gnt_idx];

    always_comb begin
        we3_d       = 1'b0;
        a3_d        = a3_q;
        wd3_d       = wd3_q;
        ptr_d       = ptr_q;
        init_done_d = run_next;
        if (!in_run) begin
            we3_d = 1'b1;
            a3_d  = init_addr;
            wd3_d = '0;
        end else if (hs) begin
            ptr_d = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + PW'(1);
            if (sel_addr != '0) begin
                we3_d = 1'b1;
                a3_d  = sel_addr;
                wd3_d = sel_data;
            end else begin
                // Register 0 is hardwired: accept the request but post
                // nothing, and clear the port so no stale value lingers.
                a3_d  = '0;
                wd3_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3_q       <= 1'b0;
            a3_q        <= '0;
            wd3_q       <= '0;
            ptr_q       <= '0;
            init_done_q <= init_done_rst;
        end else begin
            we3_q       <= we3_d;
            a3_q        <= a3_d;
            wd3_q       <= wd3_d;
            ptr_q       <= ptr_d;
            init_done_q <= init_done_d;
        end
    end

    assign we3       = we3_q;
    assign a3        = a3_q;
    assign wd3       = wd3_q;
    assign init_done = init_done_q;

endmodule
